// File: rtl/ifstmt_trace_pkg.sv
// Shared types and helpers for the ifstmt trace capture stage.
package ifstmt_trace_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CHK_ROT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data_out;
        logic [DATA_W-1:0] comb_preview;
    } trace_entry_t;

    // Rotate-left by CHK_ROT, then fold in the new sample.
    function automatic logic [DATA_W-1:0] chk_next(input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
        return ((c << CHK_ROT) | (c >> (DATA_W - CHK_ROT))) ^ d;
    endfunction

endpackage

// File: rtl/ifstmt_trace_capture_if.sv
// Valid/ready read port carrying drained trace entries.
interface ifstmt_trace_capture_if;
    import ifstmt_trace_pkg::*;

    logic         rd_valid;
    logic         rd_ready;
    trace_entry_t rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/trace_ring_buf.sv
// DEPTH-entry trace storage: synchronous write, combinational read, no reset.
module trace_ring_buf
    import ifstmt_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  trace_entry_t             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output trace_entry_t             o_rd_data
);

    trace_entry_t r_mem [DEPTH];

    // Write port; contents are only reachable through a valid entry count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/ifstmt_trace_capture.sv
// Trace capture for ifstmt_top: circular pre/post-trigger buffer drained
// oldest-first over a valid/ready port, plus a branch_flag edge counter.
// Optional rolling checksum of captured data_out: IFSTMT_TRACE_CHECKSUM_EN.
module ifstmt_trace_capture
    import ifstmt_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic [7:0]                    data_out,
    input  logic                          branch_flag,
    input  logic [7:0]                    comb_preview,
    output logic [1:0]                    state,
    output logic [7:0]                    flag_edges,
    output logic [7:0]                    checksum,
    output logic                          done,
    ifstmt_trace_capture_if.master        rd
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_state_t  r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_post_cnt;
    logic          r_prev_flag;
    logic [7:0]    r_flag_edges;
    logic          r_done;

    logic          w_trig;
    logic          w_wr_en;
    logic          w_accept;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    trace_entry_t  w_wr_entry;
    trace_entry_t  w_rd_entry;

    assign w_trig       = branch_flag && !r_prev_flag;
    assign w_wr_en      = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    assign w_count_nxt  = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
    assign w_wr_entry   = {data_out, comb_preview};

    assign rd.rd_valid  = (r_state == ST_DRAIN);
    assign w_accept     = rd.rd_valid && rd.rd_ready;
    assign rd.rd_data   = rd.rd_valid ? w_rd_entry : trace_entry_t'(16'h0000);

    assign state        = r_state;
    assign flag_edges   = r_flag_edges;
    assign done         = r_done;

    trace_ring_buf #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .i_we      (w_wr_en),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // branch_flag edge detector and free-running rising-edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_flag  <= 1'b0;
            r_flag_edges <= 8'h00;
        end else begin
            r_prev_flag <= branch_flag;
            if (w_trig) begin
                r_flag_edges <= r_flag_edges + 8'(1);
            end
        end
    end

    // Capture FSM with write/read pointers, entry count and post counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                r_count  <= w_count_nxt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_count <= '0;
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        r_post_cnt <= AW'(POST_TRIG);
                        r_state    <= ST_POST;
                    end
                end
                ST_POST: begin
                    r_post_cnt <= r_post_cnt - AW'(1);
                    if (r_post_cnt == AW'(1)) begin
                        // Oldest entry sits count slots behind the post-write pointer.
                        r_rd_ptr <= w_wr_ptr_nxt - w_count_nxt[AW-1:0];
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_count  <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef IFSTMT_TRACE_CHECKSUM_EN
    logic [7:0] r_checksum;

    // Rolling checksum over every buffer write; cleared when arm is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 8'h00;
        end else if ((r_state == ST_IDLE) && arm) begin
            r_checksum <= 8'h00;
        end else if (w_wr_en) begin
            r_checksum <= chk_next(r_checksum, data_out);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_ifstmt_trace_capture.sv
// Directed self-checking bench for ifstmt_trace_capture (DEPTH=8, POST_TRIG=4).
module tb_ifstmt_trace_capture;
    import ifstmt_trace_pkg::*;

`ifdef IFSTMT_TRACE_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm;
    logic [7:0] data_out;
    logic       branch_flag;
    logic [7:0] comb_preview;
    logic [1:0] state;
    logic [7:0] flag_edges;
    logic [7:0] checksum;
    logic       done;

    ifstmt_trace_capture_if rd_if ();

    ifstmt_trace_capture #(
        .DEPTH     (8),
        .POST_TRIG (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .data_out     (data_out),
        .branch_flag  (branch_flag),
        .comb_preview (comb_preview),
        .state        (state),
        .flag_edges   (flag_edges),
        .checksum     (checksum),
        .done         (done),
        .rd           (rd_if)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_edges;
    logic       prev_f;
    logic [7:0] exp_chk;

    function automatic logic [7:0] rotx(input logic [7:0] c, input logic [7:0] d);
        return {c[6:0], c[7]} ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit later.
    task automatic step(input logic a, input logic [7:0] d, input logic f);
        arm          = a;
        data_out     = d;
        comb_preview = ~d;
        branch_flag  = f;
        @(posedge clk);
        if (f && !prev_f) exp_edges++;
        prev_f = f;
        #1;
    endtask

    // A cycle the bench knows writes the buffer.
    task automatic wstep(input logic [7:0] d, input logic f);
        step(1'b0, d, f);
        exp_chk = rotx(exp_chk, d);
    endtask

    task automatic chk_sum(input string tag);
        chk(tag, 32'(checksum), CHK_EN ? 32'(exp_chk) : 32'h0);
    endtask

    // Drain n contiguous entries starting at data value 'first', ready held high.
    task automatic drain_seq(input string tag, input logic [7:0] first, input int n);
        logic [7:0] v;
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            v = first + 8'(i);
            chk({tag, "_valid"}, 32'(rd_if.rd_valid), 32'h1);
            chk({tag, "_data"}, 32'(rd_if.rd_data), 32'({v, ~v}));
            chk({tag, "_done_low"}, 32'(done), 32'h0);
            step(1'b0, 8'h00, 1'b0);
        end
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_idle"}, 32'(state), 32'h0);
        chk({tag, "_valid_off"}, 32'(rd_if.rd_valid), 32'h0);
        chk({tag, "_data_zero"}, 32'(rd_if.rd_data), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        chk({tag, "_done_pulse"}, 32'(done), 32'h0);
        rd_if.rd_ready = 1'b0;
    endtask

    initial begin
        logic rdy;
        int   idx;
        logic [7:0] v;

        rst_n          = 1'b0;
        arm            = 1'b1;
        branch_flag    = 1'b1;
        data_out       = 8'h00;
        comb_preview   = 8'h00;
        rd_if.rd_ready = 1'b0;
        exp_edges      = 0;
        prev_f         = 1'b0;
        exp_chk        = 8'h00;

        // Reset held with arm and branch_flag high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_valid", 32'(rd_if.rd_valid), 32'h0);
        chk("rst_data", 32'(rd_if.rd_data), 32'h0);
        chk("rst_edges", 32'(flag_edges), 32'h0);
        chk("rst_chk", 32'(checksum), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b1);
        exp_chk = 8'h00;
        chk("rel_edges", 32'(flag_edges), 32'h1);
        chk("rel_state", 32'(state), 32'(ST_ARMED));

        // Basic capture: 1,2,3 pre-trigger, trigger at 4, post 5..8.
        wstep(8'h01, 1'b0);
        wstep(8'h02, 1'b0);
        wstep(8'h03, 1'b0);
        wstep(8'h04, 1'b1);
        chk("t1_post", 32'(state), 32'(ST_POST));
        chk("t1_edges", 32'(flag_edges), 32'(exp_edges));
        wstep(8'h05, 1'b0);
        wstep(8'h06, 1'b0);
        wstep(8'h07, 1'b0);
        chk("t1_still_post", 32'(state), 32'(ST_POST));
        wstep(8'h08, 1'b0);
        chk("t1_drain", 32'(state), 32'(ST_DRAIN));
        chk_sum("t1_chk");
        drain_seq("t1", 8'h01, 8);
        chk_sum("t1_chk_hold");

        // Long pre-trigger run overwrites oldest entries.
        step(1'b1, 8'h00, 1'b0);
        exp_chk = 8'h00;
        chk("t3_armed", 32'(state), 32'(ST_ARMED));
        for (int i = 0; i < 20; i++) wstep(8'h10 + 8'(i), 1'b0);
        chk("t3_no_trig", 32'(state), 32'(ST_ARMED));
        wstep(8'h24, 1'b1);
        chk("t3_post", 32'(state), 32'(ST_POST));
        for (int i = 0; i < 4; i++) wstep(8'h25 + 8'(i), 1'b0);
        chk("t3_drain", 32'(state), 32'(ST_DRAIN));
        chk_sum("t3_chk");
        drain_seq("t3", 8'h21, 8);

        // Stalled drain with arm pulses and flag edges during DRAIN.
        step(1'b1, 8'h00, 1'b0);
        exp_chk = 8'h00;
        wstep(8'h60, 1'b0);
        wstep(8'h61, 1'b0);
        wstep(8'h62, 1'b0);
        wstep(8'h63, 1'b1);
        for (int i = 0; i < 4; i++) wstep(8'h64 + 8'(i), 1'b0);
        chk("t4_drain", 32'(state), 32'(ST_DRAIN));
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            rdy = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            rd_if.rd_ready = rdy;
            v = 8'h60 + 8'(idx);
            chk("t4_valid", 32'(rd_if.rd_valid), 32'h1);
            chk("t4_data", 32'(rd_if.rd_data), 32'({v, ~v}));
            step(!rdy, 8'hAA, (c % 2) == 0);
            if (rdy) idx++;
            if (idx < 8) chk("t4_stay_drain", 32'(state), 32'(ST_DRAIN));
        end
        chk("t4_count", 32'(idx), 32'h8);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_idle", 32'(state), 32'h0);
        chk("t4_edges", 32'(flag_edges), 32'(exp_edges));
        rd_if.rd_ready = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        chk("t4_done_pulse", 32'(done), 32'h0);
        chk("t4_still_idle", 32'(state), 32'h0);

        // Checksum on 0x01, 0x02.
        step(1'b1, 8'h00, 1'b0);
        exp_chk = 8'h00;
        wstep(8'h01, 1'b0);
        chk("t5_chk1", 32'(checksum), CHK_EN ? 32'h01 : 32'h0);
        wstep(8'h02, 1'b0);
        chk("t5_chk2", 32'(checksum), 32'h00);
        wstep(8'h03, 1'b1);
        wstep(8'h04, 1'b0);
        chk("t5_post", 32'(state), 32'(ST_POST));

        // Asynchronous reset mid-POST, then re-arm with immediate trigger.
        rst_n = 1'b0;
        #1;
        chk("t6_state", 32'(state), 32'h0);
        chk("t6_valid", 32'(rd_if.rd_valid), 32'h0);
        chk("t6_edges", 32'(flag_edges), 32'h0);
        chk("t6_chk", 32'(checksum), 32'h0);
        exp_edges = 0;
        prev_f    = 1'b0;
        exp_chk   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b0);
        chk("t6_armed", 32'(state), 32'(ST_ARMED));
        wstep(8'h50, 1'b1);
        chk("t6_post", 32'(state), 32'(ST_POST));
        for (int i = 0; i < 4; i++) wstep(8'h51 + 8'(i), 1'b0);
        chk("t6_drain", 32'(state), 32'(ST_DRAIN));
        chk_sum("t6_chk_run");
        drain_seq("t6", 8'h50, 5);
        chk("t6_edges_end", 32'(flag_edges), 32'(exp_edges));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
